paddle_hit_ctrl: RTL



---
 rtl/paddle_hit_ctrl.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/paddle_hit_ctrl.sv
// ---------------------------------------------------------------------------
// paddle_hit_ctrl
//
// Turns four raw push buttons into two rate-limited paddle positions and
// compares them with the current ball coordinates. It produces the
// registered hit levels that the ball mover samples on each ball step. It
// also produces one-cycle miss pulses for the scorekeeper.
//
// Optional feature macro: PADDLE_AI_RIGHT_EN
//   defined   : the right paddle follows ball_y on its own. The right
//               buttons are ignored and their synchronizers and debouncers
//               are not built.
//   undefined : the right paddle is button-driven, the same as the left.
//
// Parameters
//   PADDLE_H         paddle height in rows (1..8)
//   DEBOUNCE_CYCLES  consecutive stable cycles before a button change is
//                    accepted (>=2)
//   MOVE_DIV         clk cycles per paddle move tick (>=2)
//   Y_MIN, Y_MAX     topmost / bottommost playable row
//
// Ports
//   clk                   system clock
//   reset                 asynchronous, active-low reset
//   btn_l_up, btn_l_dn    raw left-paddle buttons (async, active-high)
//   btn_r_up, btn_r_dn    raw right-paddle buttons (async, active-high)
//   ball_x [5:0]          ball column 0..63
//   ball_y [4:0]          ball row 0..31
//   left_top  [4:0]       top row of the left paddle
//   right_top [4:0]       top row of the right paddle
//   hit_left              ball at column 1 inside the left paddle span
//   hit_right             ball at column 62 inside the right paddle span
//   miss_left             one-cycle pulse when ball_x enters column 0
//   miss_right            one-cycle pulse when ball_x enters column 63
// ---------------------------------------------------------------------------
module paddle_hit_ctrl #(
    parameter int PADDLE_H        = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int MOVE_DIV        = 250000,
    parameter int Y_MIN           = 1,
    parameter int Y_MAX           = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_l_up,
    input  logic       btn_l_dn,
    input  logic       btn_r_up,
    input  logic       btn_r_dn,
    input  logic [5:0] ball_x,
    input  logic [4:0] ball_y,
    output logic [4:0] left_top,
    output logic [4:0] right_top,
    output logic       hit_left,
    output logic       hit_right,
    output logic       miss_left,
    output logic       miss_right
);

    // Counter widths and the constants used at the span width. Bottom-row
    // arithmetic uses 6 bits so that top+PADDLE_H-1 cannot wrap.
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int MV_W = $clog2(MOVE_DIV);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [MV_W-1:0] MV_LAST = MV_W'(MOVE_DIV - 1);

    localparam logic [5:0] YMIN6   = 6'(Y_MIN);
    localparam logic [5:0] YMAX6   = 6'(Y_MAX);
    localparam logic [5:0] SPAN_M1 = 6'(PADDLE_H - 1);
    localparam logic [4:0] TOP_RST = 5'((Y_MIN + Y_MAX + 1 - PADDLE_H) / 2);

    // -----------------------------------------------------------------------
    // Button set. Bit order: left up, left down, then right up, right down
    // when the right paddle is button-driven.
    // -----------------------------------------------------------------------
`ifdef PADDLE_AI_RIGHT_EN
    localparam int NBTN = 2;
    logic [NBTN-1:0] btn_raw;
    logic            unused_right_btns;

    assign btn_raw           = {btn_l_dn, btn_l_up};
    assign unused_right_btns = btn_r_up | btn_r_dn;
`else
    localparam int NBTN = 4;
    logic [NBTN-1:0] btn_raw;

    assign btn_raw = {btn_r_dn, btn_r_up, btn_l_dn, btn_l_up};
`endif

    logic [NBTN-1:0] sync_p0;
    logic [NBTN-1:0] sync_p1;
    logic [NBTN-1:0] db;
    logic [DB_W-1:0] db_cnt [NBTN];

    // ---- stage: two-flop synchronizer for the asynchronous buttons -------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= btn_raw;
            sync_p1 <= sync_p0;
        end
    end

    // ---- stage: debounce -------------------------------------------------
    // Each counter counts consecutive cycles where the synchronized level
    // disagrees with the accepted level. Agreement clears it. Reaching the
    // last count accepts the new level. A glitch therefore has to survive
    // DEBOUNCE_CYCLES cycles in a row to get through.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            db <= '0;
            for (int i = 0; i < NBTN; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NBTN; i++) begin
                if (sync_p1[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db[i]     <= ~db[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // ---- stage: move tick ------------------------------------------------
    logic [MV_W-1:0] mv_cnt;
    logic            tick;

    assign tick = (mv_cnt == MV_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mv_cnt <= '0;
        end else if (tick) begin
            mv_cnt <= '0;
        end else begin
            mv_cnt <= mv_cnt + MV_W'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Paddle step helpers. Both keep the top inside
    // [Y_MIN, Y_MAX-PADDLE_H+1] by refusing a step that would leave the
    // playfield.
    // -----------------------------------------------------------------------
    function automatic logic [5:0] bottom_of(input logic [4:0] top);
        return {1'b0, top} + SPAN_M1;
    endfunction

    function automatic logic [4:0] button_step(input logic [4:0] top,
                                               input logic       up,
                                               input logic       dn);
        logic [4:0] nxt;
        nxt = top;
        if (up && !dn && ({1'b0, top} > YMIN6)) begin
            nxt = top - 5'd1;
        end else if (dn && !up && (bottom_of(top) < YMAX6)) begin
            nxt = top + 5'd1;
        end
        return nxt;
    endfunction

`ifdef PADDLE_AI_RIGHT_EN
    // Moves one row toward covering the ball row. It holds once the ball
    // row lies inside the paddle span.
    function automatic logic [4:0] track_step(input logic [4:0] top,
                                              input logic [4:0] row);
        logic [4:0] nxt;
        nxt = top;
        if ((row < top) && ({1'b0, top} > YMIN6)) begin
            nxt = top - 5'd1;
        end else if (({1'b0, row} > bottom_of(top)) && (bottom_of(top) < YMAX6)) begin
            nxt = top + 5'd1;
        end
        return nxt;
    endfunction
`endif

    logic [4:0] left_nxt;
    logic [4:0] right_nxt;

    assign left_nxt  = button_step(left_top, db[0], db[1]);
`ifdef PADDLE_AI_RIGHT_EN
    assign right_nxt = track_step(right_top, ball_y);
`else
    assign right_nxt = button_step(right_top, db[2], db[3]);
`endif

    // ---- stage: paddle position registers --------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            left_top  <= TOP_RST;
            right_top <= TOP_RST;
        end else if (tick) begin
            left_top  <= left_nxt;
            right_top <= right_nxt;
        end
    end

    // Hit tests use the top values present this cycle. A paddle step taken
    // on the same edge therefore shows up in the hit result one cycle later.
    logic in_left_span;
    logic in_right_span;

    assign in_left_span  = (ball_y >= left_top)  && ({1'b0, ball_y} <= bottom_of(left_top));
    assign in_right_span = (ball_y >= right_top) && ({1'b0, ball_y} <= bottom_of(right_top));

    // ---- stage: hit / miss registers -------------------------------------
    logic [5:0] prev_x;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_left   <= 1'b0;
            hit_right  <= 1'b0;
            miss_left  <= 1'b0;
            miss_right <= 1'b0;
            prev_x     <= '0;
        end else begin
            hit_left   <= (ball_x == 6'd1)  && in_left_span;
            hit_right  <= (ball_x == 6'd62) && in_right_span;
            // Edge detect on column entry: one pulse even if the ball parks.
            miss_left  <= (ball_x == 6'd0)  && (prev_x != 6'd0);
            miss_right <= (ball_x == 6'd63) && (prev_x != 6'd63);
            prev_x     <= ball_x;
        end
    end

endmodule
